// File: rtl/gsu_pkg.sv
// Shared GSU register-select definitions: operation classes and register constants.
package gsu_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_TO   = 3'd1,
    OP_FROM = 3'd2,
    OP_WITH = 3'd3,
    OP_EXEC = 3'd4
  } op_kind_t;

  localparam int GSU_NUM_REGS = 16;
  localparam int GSU_REG_R0   = 0;

endpackage

// File: rtl/onehot_decoder.sv
// Index to one-hot decoder; the output is all-zero when the index is >= N.
module onehot_decoder #(
  parameter int WIDTH = 4,
  parameter int N     = 16
) (
  input  logic [WIDTH-1:0] index,
  output logic [N-1:0]     onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (index == WIDTH'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/gsu_reg_select.sv
// GSU register-prefix tracker (TO/FROM/WITH, B-flag moves) with one-hot Sreg/Dreg selects.
// Define GSU_REG_SELECT_ONEHOT_REG_EN to hold the one-hot selects in dedicated flops.
module gsu_reg_select
  import gsu_pkg::*;
#(
  parameter int NUM_REGS = GSU_NUM_REGS,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [2:0]          op_kind,
  input  logic [SEL_W-1:0]    op_reg,
  input  logic                flush,
  output logic [SEL_W-1:0]    src_idx,
  output logic [SEL_W-1:0]    dst_idx,
  output logic [NUM_REGS-1:0] src_onehot,
  output logic [NUM_REGS-1:0] dst_onehot,
  output logic                b_flag,
  output logic                move_valid,
  output logic [SEL_W-1:0]    move_src,
  output logic [SEL_W-1:0]    move_dst,
  output logic                sel_err
);

  localparam logic [SEL_W:0]   REG_LIM = (SEL_W+1)'(NUM_REGS);
  localparam logic [SEL_W-1:0] R0      = SEL_W'(GSU_REG_R0);

  op_kind_t         op;
  logic             oor;
  logic [SEL_W-1:0] src_n, dst_n, msrc_n, mdst_n;
  logic             b_n, mv_n, err_n;

  assign op  = op_kind_t'(op_kind);
  assign oor = ({1'b0, op_reg} >= REG_LIM);

  always_comb begin
    src_n  = src_idx;
    dst_n  = dst_idx;
    b_n    = b_flag;
    mv_n   = 1'b0;
    msrc_n = R0;
    mdst_n = R0;
    err_n  = 1'b0;
    if (flush) begin
      src_n = R0;
      dst_n = R0;
      b_n   = 1'b0;
    end else if (instr_valid) begin
      unique case (op)
        OP_TO, OP_FROM, OP_WITH: begin
          if (oor) begin
            err_n = 1'b1;
          end else if (op == OP_WITH) begin
            src_n = op_reg;
            dst_n = op_reg;
            b_n   = 1'b1;
          end else if (b_flag) begin
            // B-mode TO is MOVE, B-mode FROM is MOVES; both end the prefix
            mv_n   = 1'b1;
            msrc_n = (op == OP_TO) ? src_idx : op_reg;
            mdst_n = (op == OP_TO) ? op_reg : dst_idx;
            src_n  = R0;
            dst_n  = R0;
            b_n    = 1'b0;
          end else if (op == OP_TO) begin
            dst_n = op_reg;
          end else begin
            src_n = op_reg;
          end
        end
        OP_EXEC: begin
          src_n = R0;
          dst_n = R0;
          b_n   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_idx    <= R0;
      dst_idx    <= R0;
      b_flag     <= 1'b0;
      move_valid <= 1'b0;
      move_src   <= R0;
      move_dst   <= R0;
      sel_err    <= 1'b0;
    end else begin
      src_idx    <= src_n;
      dst_idx    <= dst_n;
      b_flag     <= b_n;
      move_valid <= mv_n;
      move_src   <= msrc_n;
      move_dst   <= mdst_n;
      sel_err    <= err_n;
    end
  end

`ifdef GSU_REG_SELECT_ONEHOT_REG_EN
  logic [NUM_REGS-1:0] src_oh_n, dst_oh_n;

  // Decode the next-state indices so the registered selects line up with src_idx/dst_idx.
  onehot_decoder #(.WIDTH(SEL_W), .N(NUM_REGS)) u_src_dec (.index(src_n), .onehot(src_oh_n));
  onehot_decoder #(.WIDTH(SEL_W), .N(NUM_REGS)) u_dst_dec (.index(dst_n), .onehot(dst_oh_n));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_onehot <= NUM_REGS'(1);
      dst_onehot <= NUM_REGS'(1);
    end else begin
      src_onehot <= src_oh_n;
      dst_onehot <= dst_oh_n;
    end
  end
`else
  onehot_decoder #(.WIDTH(SEL_W), .N(NUM_REGS)) u_src_dec (.index(src_idx), .onehot(src_onehot));
  onehot_decoder #(.WIDTH(SEL_W), .N(NUM_REGS)) u_dst_dec (.index(dst_idx), .onehot(dst_onehot));
`endif

endmodule
